// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer: drives an external 4-bit ripple-carry adder one nibble
// per cycle (LSB first), chaining Cout into Cin, and returns the assembled
// W-bit sum/difference with carry, overflow, zero and negative flags over a
// valid/ready response channel. Subtraction uses B inverted plus Cin=1.
`timescale 1ns/1ps
module rca_nibble_sequencer #(
   parameter int NIBBLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [4*NIBBLES-1:0] req_a,
   input  logic [4*NIBBLES-1:0] req_b,
   input  logic                 req_sub,
   input  logic                 req_signed,
   output logic [3:0]           rca_a,
   output logic [3:0]           rca_b,
   output logic                 rca_cin,
   input  logic [3:0]           rca_s,
   input  logic                 rca_cout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*NIBBLES-1:0] rsp_result,
   output logic                 rsp_carry,
   output logic                 rsp_overflow,
   output logic                 rsp_zero,
   output logic                 rsp_negative
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;          // effective B (already inverted for sub)
   logic               sub_q, sub_d;
   logic               signed_q, signed_d;
   logic [W-1:0]       res_q, res_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [3:0]         rca_a_q, rca_a_d;
   logic [3:0]         rca_b_q, rca_b_d;
   logic               rca_cin_q, rca_cin_d;

   logic               accept;
   logic               last_nib;
   logic [W-1:0]       b_eff;

   assign accept   = req_valid && req_ready;
   assign last_nib = (int'(idx_q) >= NIBBLES - 1);
   assign b_eff    = req_sub ? ~req_b : req_b;

   assign rca_a   = rca_a_q;
   assign rca_b   = rca_b_q;
   assign rca_cin = rca_cin_q;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept from IDLE or on the retiring DONE edge, leave EXEC after the top nibble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: if (last_nib) state_d = DONE;
         DONE: if (rsp_ready) state_d = accept ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and response outputs; response fields are zero unless rsp_valid.
   always_comb begin
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      rsp_result   = '0;
      rsp_carry    = 1'b0;
      rsp_overflow = 1'b0;
      rsp_zero     = 1'b0;
      rsp_negative = 1'b0;
      case (state_q)
         IDLE: req_ready = 1'b1;
         DONE: begin
            req_ready    = rsp_ready;
            rsp_valid    = 1'b1;
            rsp_result   = res_q;
            rsp_carry    = carry_q;
            rsp_zero     = (res_q == '0);
            rsp_negative = res_q[W-1];
            if (signed_q) begin
               rsp_overflow = (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1]);
            end else begin
               rsp_overflow = sub_q ? ~carry_q : carry_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath next-state: load operands on accept, capture one adder nibble per EXEC cycle.
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      signed_d  = signed_q;
      res_d     = res_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      rca_a_d   = 4'd0;
      rca_b_d   = 4'd0;
      rca_cin_d = 1'b0;
      if (accept) begin
         a_d       = req_a;
         b_d       = b_eff;
         sub_d     = req_sub;
         signed_d  = req_signed;
         res_d     = '0;
         carry_d   = 1'b0;
         idx_d     = '0;
         rca_a_d   = req_a[3:0];
         rca_b_d   = b_eff[3:0];
         rca_cin_d = req_sub;
      end else if (state_q == EXEC) begin
         carry_d = rca_cout;
         for (int k = 0; k < NIBBLES; k++) begin
            if (k == int'(idx_q)) res_d[4*k +: 4] = rca_s;
         end
         if (!last_nib) begin
            idx_d     = idx_q + 1'b1;
            rca_cin_d = rca_cout;
            for (int k = 1; k < NIBBLES; k++) begin
               if (k == int'(idx_q) + 1) begin
                  rca_a_d = a_q[4*k +: 4];
                  rca_b_d = b_q[4*k +: 4];
               end
            end
         end
      end
   end

   // Datapath registers, all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         signed_q  <= 1'b0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         rca_a_q   <= 4'd0;
         rca_b_q   <= 4'd0;
         rca_cin_q <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         sub_q     <= sub_d;
         signed_q  <= signed_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         idx_q     <= idx_d;
         rca_a_q   <= rca_a_d;
         rca_b_q   <= rca_b_d;
         rca_cin_q <= rca_cin_d;
      end
   end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Testbench for rca_nibble_sequencer (NIBBLES=2) with a behavioural 4-bit adder.
`timescale 1ns/1ps
module tb_rca_nibble_sequencer;

   localparam int NIB = 2;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         req_sub = 1'b0;
   logic         req_signed = 1'b0;
   logic [3:0]   rca_a, rca_b, rca_s;
   logic         rca_cin, rca_cout;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_result;
   logic         rsp_carry, rsp_overflow, rsp_zero, rsp_negative;

   int n_checks = 0;
   int n_fail   = 0;

   // External ripple-carry adder
   logic [4:0] add_sum;
   assign add_sum  = {1'b0, rca_a} + {1'b0, rca_b} + {4'd0, rca_cin};
   assign rca_s    = add_sum[3:0];
   assign rca_cout = add_sum[4];

   always #5 clk = ~clk;

   rca_nibble_sequencer #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_signed(req_signed),
      .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
      .rca_s(rca_s), .rca_cout(rca_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
      .rsp_zero(rsp_zero), .rsp_negative(rsp_negative)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic       sgn;
      logic [7:0] res;
      logic       c;
      logic       ovf;
      logic       z;
      logic       n;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, " rsp_result"}, {24'd0, rsp_result}, 32'd0);
      chk({tag, " rca_a/b/cin"}, {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
      chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      // a, b, sub, signed, result, carry, overflow, zero, negative
      vecs[0] = '{8'h35, 8'h5B, 1'b0, 1'b0, 8'h90, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'h08, 8'h02, 1'b1, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h02, 8'h08, 1'b1, 1'b0, 8'hFA, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'h70, 8'h10, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{8'h70, 8'h10, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'hFC, 8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset state
      tick();
      tick();
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_idle_outputs("post-reset");

      // Table-driven operations
      foreach (vecs[i]) begin
         logic [7:0] beff;
         logic [4:0] n0;
         beff = vecs[i].sub ? ~vecs[i].b : vecs[i].b;
         n0   = {1'b0, vecs[i].a[3:0]} + {1'b0, beff[3:0]} + {4'd0, vecs[i].sub};
         req_a = vecs[i].a; req_b = vecs[i].b;
         req_sub = vecs[i].sub; req_signed = vecs[i].sgn;
         req_valid = 1'b1;
         rsp_ready = 1'b0;
         chk($sformatf("v%0d req_ready idle", i), {31'd0, req_ready}, 32'd1);
         tick();
         req_valid = 1'b0;
         chk($sformatf("v%0d nib0 a", i), {28'd0, rca_a}, {28'd0, vecs[i].a[3:0]});
         chk($sformatf("v%0d nib0 b", i), {28'd0, rca_b}, {28'd0, beff[3:0]});
         chk($sformatf("v%0d nib0 cin", i), {31'd0, rca_cin}, {31'd0, vecs[i].sub});
         chk($sformatf("v%0d exec req_ready", i), {31'd0, req_ready}, 32'd0);
         chk($sformatf("v%0d rsp_valid c1", i), {31'd0, rsp_valid}, 32'd0);
         tick();
         chk($sformatf("v%0d nib1 a", i), {28'd0, rca_a}, {28'd0, vecs[i].a[7:4]});
         chk($sformatf("v%0d nib1 b", i), {28'd0, rca_b}, {28'd0, beff[7:4]});
         chk($sformatf("v%0d nib1 cin", i), {31'd0, rca_cin}, {31'd0, n0[4]});
         chk($sformatf("v%0d rsp_valid c2", i), {31'd0, rsp_valid}, 32'd0);
         tick();
         chk($sformatf("v%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("v%0d result", i), {24'd0, rsp_result}, {24'd0, vecs[i].res});
         chk($sformatf("v%0d carry", i), {31'd0, rsp_carry}, {31'd0, vecs[i].c});
         chk($sformatf("v%0d overflow", i), {31'd0, rsp_overflow}, {31'd0, vecs[i].ovf});
         chk($sformatf("v%0d zero", i), {31'd0, rsp_zero}, {31'd0, vecs[i].z});
         chk($sformatf("v%0d negative", i), {31'd0, rsp_negative}, {31'd0, vecs[i].n});
         chk($sformatf("v%0d done rca", i), {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         check_idle_outputs($sformatf("v%0d retired", i));
      end

      // Backpressure: response held, busy request ignored, then back-to-back accept
      req_a = 8'h35; req_b = 8'h5B; req_sub = 1'b0; req_signed = 1'b0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      req_a = 8'hAA; req_b = 8'h01; req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp hold%0d valid", c), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp hold%0d result", c), {24'd0, rsp_result}, 32'h90);
         chk($sformatf("bp hold%0d neg", c), {31'd0, rsp_negative}, 32'd1);
         chk($sformatf("bp hold%0d req_ready", c), {31'd0, req_ready}, 32'd0);
         tick();
         req_valid = 1'b0;
      end
      chk("bp hold end result", {24'd0, rsp_result}, 32'h90);
      req_a = 8'h11; req_b = 8'h22; req_sub = 1'b0; req_valid = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("b2b req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0;
      chk("b2b rsp_valid drop", {31'd0, rsp_valid}, 32'd0);
      chk("b2b rsp_result zero", {24'd0, rsp_result}, 32'd0);
      chk("b2b nib0 a", {28'd0, rca_a}, 32'd1);
      chk("b2b nib0 b", {28'd0, rca_b}, 32'd2);
      tick();
      chk("b2b rsp_valid c2", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("b2b rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("b2b result", {24'd0, rsp_result}, 32'h33);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_idle_outputs("b2b retired");

      // Asynchronous reset in the middle of EXEC
      req_a = 8'h35; req_b = 8'h5B; req_sub = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rst pre rca_a", {28'd0, rca_a}, 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async rst");
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("rst no rsp%0d", c), {31'd0, rsp_valid}, 32'd0);
      end
      rsp_ready = 1'b0;

      // Asynchronous reset while a response is pending
      req_a = 8'h70; req_b = 8'h10; req_signed = 1'b1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("rst2 pre valid", {31'd0, rsp_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async rst done");
      chk("rst2 flags", {28'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_negative}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst2 no rsp", {31'd0, rsp_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
